// File: rtl/uart_pw_check.sv
// UART (8N1) receiver feeding an 8-byte password checker.
// Drives active-low LEDs: green = unlocked (sticky), red = last attempt failed.
module uart_pw_check #(
   parameter int unsigned CLK_HZ   = 12000000,
   parameter int unsigned BAUD     = 115200,
   parameter logic [63:0] PASSWORD = 64'h3231656d6b636168,
   parameter int unsigned GAP_BITS = 20
) (
   input  logic       clk_12,
   input  logic       reset_n,
   input  logic       uart,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       led_green,
   output logic       led_red
);

   localparam int unsigned BAUD_P  = CLK_HZ / BAUD;
   localparam int unsigned HALF_P  = BAUD_P / 2;
   localparam int unsigned CNT_W   = (BAUD_P > 2) ? $clog2(BAUD_P) : 1;
   localparam int unsigned GAP_LIM = GAP_BITS * BAUD_P;
   localparam int unsigned GAP_W   = (GAP_LIM > 2) ? $clog2(GAP_LIM) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]       sync_q, sync_d;
   logic             line_prev_q, line_prev_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [2:0]       char_idx_q, char_idx_d;
   logic             match_q, match_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             led_green_q, led_green_d;
   logic             led_red_q, led_red_d;

   logic             line;
   logic             start_edge;
   logic             cnt_wrap;
   logic [CNT_W-1:0] cnt_inc;
   logic [7:0]       pw_byte;
   logic             match_now;
   logic             gap_run;
   logic             gap_hit;

   assign line        = sync_q[1];
   assign sync_d      = {sync_q[0], uart};
   assign line_prev_d = line;
   assign start_edge  = line_prev_q & ~line;
   assign cnt_wrap    = (cnt_q == CNT_W'(BAUD_P - 1));
   assign cnt_inc     = cnt_wrap ? '0 : cnt_q + CNT_W'(1);

   // Receiver: next state, bit shifting and framing result
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_W'(HALF_P)) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = line ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DATA: begin
            cnt_d = cnt_inc;
            if (cnt_wrap) begin
               shift_d = {line, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            cnt_d = cnt_inc;
            if (cnt_wrap) begin
               state_d = S_IDLE;
               if (line) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pw_byte   = PASSWORD[{char_idx_q, 3'b000} +: 8];
   assign match_now = ((char_idx_q == 3'd0) ? 1'b1 : match_q) & (rx_data_q == pw_byte);
   assign gap_run   = (state_q == S_IDLE) && (char_idx_q != 3'd0);
   assign gap_hit   = gap_run && (gap_q == GAP_W'(GAP_LIM - 1));

   // Password checker; a received byte always wins over the idle timeout
   always_comb begin
      char_idx_d  = char_idx_q;
      match_d     = match_q;
      gap_d       = '0;
      led_green_d = led_green_q;
      led_red_d   = led_red_q;
      if (gap_run && !gap_hit) begin
         gap_d = gap_q + GAP_W'(1);
      end
      if (rx_valid_q) begin
         led_red_d = 1'b1;
         if (char_idx_q == 3'd7) begin
            char_idx_d = 3'd0;
            match_d    = 1'b1;
            if (match_now) begin
               led_green_d = 1'b0;
            end else begin
               led_red_d = 1'b0;
            end
         end else begin
            char_idx_d = char_idx_q + 3'd1;
            match_d    = match_now;
         end
      end else if (frame_err_q || gap_hit) begin
         char_idx_d = 3'd0;
         match_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_12 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= 2'b11;
         line_prev_q <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         char_idx_q  <= '0;
         match_q     <= 1'b1;
         gap_q       <= '0;
         led_green_q <= 1'b1;
         led_red_q   <= 1'b1;
      end else begin
         sync_q      <= sync_d;
         line_prev_q <= line_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         char_idx_q  <= char_idx_d;
         match_q     <= match_d;
         gap_q       <= gap_d;
         led_green_q <= led_green_d;
         led_red_q   <= led_red_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign led_green = led_green_q;
   assign led_red   = led_red_q;

endmodule

// File: tb/tb_uart_pw_check.sv
// Bench for uart_pw_check: directed table, corner sequences and a random byte
// stream checked against a queue-based model of the password attempt.
module tb_uart_pw_check;

   localparam int unsigned BAUD_P = 104;
   localparam logic [63:0] PW     = 64'h3231656d6b636168;

   typedef struct packed {
      logic       fe;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      logic       exp_green;
      logic       exp_red;
   } vec_t;

   logic       clk_12 = 1'b0;
   logic       reset_n;
   logic       uart;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       led_green;
   logic       led_red;

   uart_pw_check dut (
      .clk_12    (clk_12),
      .reset_n   (reset_n),
      .uart      (uart),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .led_green (led_green),
      .led_red   (led_red)
   );

   always #5 clk_12 = ~clk_12;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         ev_seen  = 0;
   ev_t        exp_q[$];
   logic [7:0] attempt[$];
   logic       m_green  = 1'b1;
   logic       m_red    = 1'b1;
   logic [7:0] m_last   = 8'h00;
   logic       led_pend = 1'b0;
   vec_t       tbl[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] pw_byte(input int k);
      logic [63:0] p;
      p = PW;
      return p[8*k +: 8];
   endfunction

   // Model: collect bytes of an attempt, judge the whole attempt once 8 are in
   function automatic void model_byte(input logic [7:0] d);
      logic ok;
      m_last = d;
      attempt.push_back(d);
      m_red = 1'b1;
      if (attempt.size() == 8) begin
         ok = 1'b1;
         for (int k = 0; k < 8; k++) if (attempt[k] != pw_byte(k)) ok = 1'b0;
         if (ok) m_green = 1'b0;
         else m_red = 1'b0;
         attempt.delete();
      end
   endfunction

   task automatic monitor_loop();
      ev_t ev;
      forever begin
         @(negedge clk_12);
         if (led_pend) begin
            check("led_green_after_event", 64'(led_green), 64'(m_green));
            check("led_red_after_event", 64'(led_red), 64'(m_red));
            led_pend = 1'b0;
         end
         if (reset_n && (rx_valid || frame_err)) begin
            ev_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_event", 64'({rx_valid, frame_err}), 64'(0));
            end else begin
               ev = exp_q.pop_front();
               check("led_green_at_event", 64'(led_green), 64'(m_green));
               check("led_red_at_event", 64'(led_red), 64'(m_red));
               check("event_frame_err", 64'(frame_err), 64'(ev.fe));
               check("event_rx_valid", 64'(rx_valid), 64'(!ev.fe));
               if (ev.fe) begin
                  check("rx_data_hold", 64'(rx_data), 64'(m_last));
                  attempt.delete();
               end else begin
                  check("rx_data", 64'(rx_data), 64'(ev.data));
                  model_byte(ev.data);
               end
               led_pend = 1'b1;
            end
         end
      end
   endtask

   task automatic drive_bit(input logic v);
      uart = v;
      repeat (BAUD_P) @(negedge clk_12);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int gap);
      exp_q.push_back('{fe: !stop_ok, data: d});
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_ok);
      if (!stop_ok) drive_bit(1'b1);
      uart = 1'b1;
      repeat (gap) @(negedge clk_12);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk_12);
         t++;
      end
      repeat (2) @(negedge clk_12);
      check({"drained_", tag}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      uart    = 1'b1;
      exp_q.delete();
      attempt.delete();
      m_green  = 1'b1;
      m_red    = 1'b1;
      m_last   = 8'h00;
      led_pend = 1'b0;
      repeat (3) @(negedge clk_12);
      check("reset_rx_data", 64'(rx_data), 64'(0));
      check("reset_rx_valid", 64'(rx_valid), 64'(0));
      check("reset_frame_err", 64'(frame_err), 64'(0));
      check("reset_led_green", 64'(led_green), 64'(1));
      check("reset_led_red", 64'(led_red), 64'(1));
      reset_n = 1'b1;
      repeat (4) @(negedge clk_12);
   endtask

   task automatic send_password(input string tag);
      for (int i = 0; i < 8; i++) begin
         send_byte(pw_byte(i), 1'b1, 6);
         if (i == 6) begin
            drain({tag, "_b7"});
            check({tag, "_locked_before_last"}, 64'(led_green), 64'(1));
         end
      end
      drain(tag);
      check({tag, "_led_green"}, 64'(led_green), 64'(0));
      check({tag, "_led_red"}, 64'(led_red), 64'(1));
   endtask

   initial begin
      int seen0;
      logic [7:0] d;
      logic stop_ok;
      int gap;

      // Directed vectors: frame error mid-attempt, wrong password, then unlock
      for (int i = 0; i < 3; i++) tbl[i] = '{pw_byte(i), 1'b1, 1'b1, 1'b1};
      tbl[3] = '{8'h6b, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++)
         tbl[4+i] = '{(i == 7) ? 8'h33 : pw_byte(i), 1'b1, 1'b1, (i == 7) ? 1'b0 : 1'b1};
      for (int i = 0; i < 8; i++)
         tbl[12+i] = '{pw_byte(i), 1'b1, (i == 7) ? 1'b0 : 1'b1, 1'b1};

      reset_n = 1'b0;
      uart    = 1'b1;
      fork
         monitor_loop();
         begin
            repeat (120000) @(posedge clk_12);
            $display("FAIL watchdog: simulation exceeded cycle budget");
            $fatal(1, "watchdog expired");
         end
      join_none

      do_reset();
      for (int i = 0; i < 20; i++) begin
         send_byte(tbl[i].data, tbl[i].stop_ok, 6);
         drain($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_led_green", i), 64'(led_green), 64'(tbl[i].exp_green));
         check($sformatf("tbl%0d_led_red", i), 64'(led_red), 64'(tbl[i].exp_red));
      end

      // Short low glitch must be rejected as a false start
      do_reset();
      seen0 = ev_seen;
      uart  = 1'b0;
      repeat (20) @(negedge clk_12);
      uart = 1'b1;
      repeat (40) @(negedge clk_12);
      check("glitch_no_event", 64'(ev_seen - seen0), 64'(0));

      // Three good bytes, idle past the timeout, then a full password
      send_byte(pw_byte(0), 1'b1, 6);
      send_byte(pw_byte(1), 1'b1, 6);
      send_byte(pw_byte(2), 1'b1, 20 * BAUD_P + 1);
      drain("gap_prefix");
      attempt.delete();
      send_password("gap_pw");

      // Reset during bit 4 of the fifth byte abandons everything
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(pw_byte(i), 1'b1, 6);
      drain("midreset_prefix");
      d = pw_byte(4);
      drive_bit(1'b0);
      for (int b = 0; b < 4; b++) drive_bit(d[b]);
      uart = d[4];
      repeat (50) @(negedge clk_12);
      do_reset();
      send_password("midreset_pw");

      // Random stream: mostly correct bytes, some wrong, some bad stop bits
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(3) != 0) d = pw_byte(attempt.size());
         else d = 8'($urandom_range(255));
         stop_ok = ($urandom_range(11) != 0);
         gap = (i == 9) ? 2300 : int'($urandom_range(40));
         send_byte(d, stop_ok, gap);
         drain($sformatf("rand%0d", i));
         if (gap >= 2300) attempt.delete();
      end
      check("rand_end_led_green", 64'(led_green), 64'(m_green));
      check("rand_end_led_red", 64'(led_red), 64'(m_red));

      drain("final");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_pw_check.md
UART_PW_CHECK -- requirements
Module: uart_pw_check

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BAUD_P = CLK_HZ/BAUD (integer division), 104 at defaults.
REQ-003 Parameter PASSWORD, default 64'h3231656d6b636168, expected 8-byte password; byte k is PASSWORD[8k+7:8k], byte 0 is received first.
REQ-004 Parameter GAP_BITS, default 20, inter-byte idle timeout in bit periods.
REQ-005 clk_12  input  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk_12.
REQ-007 uart  input  1  asynchronous serial line; idles high; 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
REQ-008 rx_data  output  8  last correctly framed byte.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is new in that cycle.
REQ-010 frame_err  output  1  one-cycle pulse on a stop bit sampled low.
REQ-011 led_green  output  1  active-low; low means unlocked.
REQ-012 led_red  output  1  active-low; low means the last complete attempt failed.

Function
REQ-013 uart SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 The receiver FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on a synchronized falling edge (previous 1, current 0); the baud counter is cleared at that edge.
REQ-016 In START, at count BAUD_P/2 (52): line low -> DATA with the counter cleared; line high -> IDLE (false start, no outputs).
REQ-017 In DATA, one bit is sampled every BAUD_P cycles (mid-bit), shifted LSB first; after the 8th bit -> STOP.
REQ-018 In STOP, after BAUD_P cycles the line is sampled: high -> rx_valid pulse with rx_data updated; low -> frame_err pulse with rx_data unchanged. Both cases -> IDLE.
REQ-019 The baud counter SHALL be wide enough for BAUD_P-1 and SHALL wrap to 0 at BAUD_P-1.
REQ-020 The checker SHALL hold char_idx (0..7) and match (1 bit); on each rx_valid it compares rx_data with PASSWORD byte char_idx.
  - match <= match AND equal; match is set to 1 when char_idx is 0.
REQ-021 On the rx_valid where char_idx==7, the verdict SHALL be registered and char_idx returns to 0.
  - all 8 equal: led_green low, led_red high.
  - otherwise: led_red low.
  - LED outputs change 1 cycle after that rx_valid.
REQ-022 led_green, once low, SHALL stay low until reset_n is asserted; later bytes do not affect it.
REQ-023 led_red SHALL return high on the next rx_valid after it went low, unless that rx_valid itself ends a failed attempt.
REQ-024 frame_err SHALL reset char_idx to 0 and discard the partial attempt; led_red is unchanged.
REQ-025 An idle gap counter SHALL run while the FSM is in IDLE with 0<char_idx<8; after GAP_BITS*BAUD_P cycles it resets char_idx to 0 with no verdict.
REQ-026 If a start edge and a gap timeout occur in the same cycle, the timeout SHALL be applied first, so the new byte becomes byte 0.

Reset
REQ-027 While reset_n is low, all of the following SHALL hold:
  - FSM in IDLE; counters, char_idx and rx_data are 0; match is 1.
  - rx_valid=0, frame_err=0, led_green=1, led_red=1.
  - synchronizer flops are 1.
REQ-028 Reset asserted mid-byte or mid-attempt SHALL abandon all progress; the first falling edge after release starts byte 0.

Verification
REQ-029 Send "hackme12" (0x68,0x61,0x63,0x6b,0x6d,0x65,0x31,0x32) at 104 cycles/bit -> 8 rx_valid pulses with those bytes; led_green low 1 cycle after the 8th pulse and held; led_red stays 1.
REQ-030 Send 0x68,0x61,0x63,0x6b,0x6d,0x65,0x31,0x33 -> led_red low, led_green 1; then send the correct password -> led_red high at its 1st rx_valid, led_green low after its 8th.
REQ-031 Drive a 20-cycle low glitch on an idle line -> no rx_valid, no frame_err, FSM back in IDLE by cycle 52 after the edge.
REQ-032 Send 3 correct bytes, then byte 0x6b with its stop bit low -> frame_err pulse, rx_data stays 0x63, char_idx=0; then the full password -> unlock.
REQ-033 Send 3 correct bytes, idle 20*104+1 cycles, then the full password -> unlock after exactly 8 further bytes.
REQ-034 Assert reset_n during bit 4 of byte 5, then release -> all outputs at reset values; the full password then unlocks.
